// File: rtl/toggle_event_arbiter_if.sv
// ---------------------------------------------------------------------------
// toggle_event_arbiter_if
//   Bundles the request, event, ack and status signals of the
//   toggle_event_arbiter so the block and its environment connect through
//   one port.
//
//   Signals
//     req_pulse     N_REQ        one-cycle event strobe per source
//     evt_pulse     1            one-cycle strobe to the pulse-to-toggle channel
//     evt_id        ID_W         granted source, held until busy falls
//     ack_toggle    1            far-side ack toggle, already in the clk domain
//     busy          1            arbiter is not idle
//     pend_mask     N_REQ        bit i set while source i has queued pulses
//     ovf_flag      N_REQ        sticky: a pulse was lost on source i
//     timeout_flag  1            sticky: an event was abandoned without ack
//     err_clr       1            clears both sticky flag groups
//     state_dbg     2            current FSM state (debug observation)
//     cnt_dbg       N_REQ*CNT_W  packed pending counters, source 0 in the LSBs
//
//   Handshake: evt_pulse is high for exactly one cycle per event, and evt_id
//   is valid from that cycle until busy falls. A new evt_pulse is only ever
//   issued after the previous event's ack toggle has been seen (one edge of
//   ack_toggle while waiting) or after that event has timed out.
//
//   Modports
//     master  the arbiter itself
//     slave   the environment driving requests and returning acks
// ---------------------------------------------------------------------------
interface toggle_event_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 4
);
    logic [N_REQ-1:0]       req_pulse;
    logic                   evt_pulse;
    logic [ID_W-1:0]        evt_id;
    logic                   ack_toggle;
    logic                   busy;
    logic [N_REQ-1:0]       pend_mask;
    logic [N_REQ-1:0]       ovf_flag;
    logic                   timeout_flag;
    logic                   err_clr;
    logic [1:0]             state_dbg;
    logic [N_REQ*CNT_W-1:0] cnt_dbg;

    modport master (
        input  req_pulse, ack_toggle, err_clr,
        output evt_pulse, evt_id, busy, pend_mask, ovf_flag, timeout_flag,
               state_dbg, cnt_dbg
    );

    modport slave (
        output req_pulse, ack_toggle, err_clr,
        input  evt_pulse, evt_id, busy, pend_mask, ovf_flag, timeout_flag,
               state_dbg, cnt_dbg
    );
endinterface

// File: rtl/toggle_event_arbiter.sv
// ---------------------------------------------------------------------------
// toggle_event_arbiter
//   Shares a single pulse-to-toggle CDC event channel between N_REQ pulse
//   sources. Each source's strobes are queued in a saturating counter; the
//   sources are served round-robin, one event in flight at a time. For each
//   event the block emits one evt_pulse with the source number on evt_id and
//   then waits for the far side's ack toggle (or a timeout) before the next
//   grant can be made.
//
//   Ports
//     clk    in  fast clock, all logic on posedge
//     rst_n  in  synchronous reset, active-low
//     bus    toggle_event_arbiter_if.master (requests, event, ack, status)
//
//   Parameters
//     N_REQ    number of requesters (>= 2)
//     ID_W     width of evt_id (>= clog2(N_REQ))
//     CNT_W    per-source pending counter width, saturating
//     TIMEOUT  cycles spent waiting for an ack before the event is dropped
// ---------------------------------------------------------------------------
module toggle_event_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    toggle_event_arbiter_if.master bus
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W:0]   PTR_MOD  = (PTR_W + 1)'(N_REQ);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [ID_W-1:0]        evt_id_q;
    logic                   ack_last_q;
    logic [TO_W-1:0]        to_cnt_q;
    logic                   to_flag_q;

    logic [N_REQ-1:0]       pend;
    logic [N_REQ-1:0]       ovf_vec;
    logic [N_REQ*CNT_W-1:0] cnt_flat;

    logic                   ack_edge;
    logic                   grant_vld;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W:0]         scan_sum;
    logic                   do_grant;
    logic                   to_fire;

    // The ack is a level toggle; any change since last cycle is one ack.
    assign ack_edge = bus.ack_toggle ^ ack_last_q;

    // -----------------------------------------------------------------------
    // Round-robin search: first pending index at or after rr_ptr, with wrap.
    // Scanning offsets from high to low lets the last hit (smallest offset)
    // win without a break.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
            if (scan_sum >= PTR_MOD) begin
                scan_sum = scan_sum - PTR_MOD;
            end
            if (pend[scan_sum[PTR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_sum[PTR_W-1:0];
            end
        end
    end

    assign do_grant = (state_q == IDLE) && grant_vld;

    // -----------------------------------------------------------------------
    // Per-source pending counters and overflow flags.
    // A request and a grant in the same cycle cancel out, so a saturated
    // counter that is being granted still accepts the new pulse.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_src
        logic [CNT_W-1:0] cnt_q;
        logic             ovf_q;
        logic             req;
        logic             grant;
        logic             lost;

        assign req   = bus.req_pulse[gi];
        assign grant = do_grant && (grant_idx == PTR_W'(gi));
        assign lost  = req && !grant && (cnt_q == CNT_MAX);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (req && !grant && !lost) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end else if (!req && grant) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                // A new loss in the clearing cycle keeps the flag set.
                ovf_q <= lost | (ovf_q & ~bus.err_clr);
            end
        end

        assign pend[gi]                     = (cnt_q != '0);
        assign ovf_vec[gi]                  = ovf_q;
        assign cnt_flat[gi*CNT_W +: CNT_W]  = cnt_q;
    end

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        to_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // An ack arriving in the last waiting cycle still counts.
                if (ack_edge) begin
                    state_d = IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    to_fire = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM state, grant bookkeeping, ack history and timeout tracking
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            evt_id_q   <= '0;
            ack_last_q <= 1'b0;
            to_cnt_q   <= '0;
            to_flag_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_last_q <= bus.ack_toggle;

            if (do_grant) begin
                evt_id_q <= ID_W'(grant_idx);
                rr_ptr_q <= (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
            end

            // to_cnt_q holds the number of WAIT_ACK cycles already spent.
            if (state_q == ISSUE) begin
                to_cnt_q <= '0;
            end else if (state_q == WAIT_ACK) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end

            to_flag_q <= to_fire | (to_flag_q & ~bus.err_clr);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.evt_pulse    = (state_q == ISSUE);
    assign bus.evt_id       = evt_id_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.pend_mask    = pend;
    assign bus.ovf_flag     = ovf_vec;
    assign bus.timeout_flag = to_flag_q;
    assign bus.state_dbg    = state_q;
    assign bus.cnt_dbg      = cnt_flat;

endmodule

// File: tb/tb_toggle_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_toggle_event_arbiter
//   Directed bench for toggle_event_arbiter. One cycle runs from negedge to
//   negedge: at each negedge the outputs (all register-derived) are checked,
//   then inputs for that cycle are driven and captured at the next posedge.
// ---------------------------------------------------------------------------
module tb_toggle_event_arbiter;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 255;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [ID_W-1:0] exp_q[$];

    toggle_event_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

    toggle_event_arbiter #(
        .N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [N_REQ-1:0] req, input logic clr);
        bus.req_pulse = req;
        bus.err_clr   = clr;
        @(negedge clk);
        bus.req_pulse = '0;
        bus.err_clr   = 1'b0;
    endtask

    task automatic ack();
        bus.ack_toggle = ~bus.ack_toggle;
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(input int i);
        return bus.cnt_dbg[i*CNT_W +: CNT_W];
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_evt_pulse"}, 32'(bus.evt_pulse), 32'd0);
        check({tag, "_evt_id"},    32'(bus.evt_id),    32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_pend"},      32'(bus.pend_mask), 32'd0);
        check({tag, "_ovf"},       32'(bus.ovf_flag),  32'd0);
        check({tag, "_tflag"},     32'(bus.timeout_flag), 32'd0);
        check({tag, "_state"},     32'(bus.state_dbg), 32'd0);
        check({tag, "_cnts"},      32'(bus.cnt_dbg),   32'd0);
    endtask

    task automatic reset_dut();
        rst_n         = 1'b0;
        bus.req_pulse = '0;
        bus.err_clr   = 1'b0;
        skip(2);
        check_zero("rst");
        rst_n = 1'b1;
        skip(2);
    endtask

    // Waits for evt_pulse; 'waited' is the number of cycles advanced.
    task automatic wait_evt(output int waited);
        waited = 0;
        while (bus.evt_pulse !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("evt_seen", 32'(bus.evt_pulse), 32'd1);
    endtask

    task automatic check_next_id(input string tag);
        logic [ID_W-1:0] exp_id;
        exp_id = exp_q.pop_front();
        check(tag, 32'(bus.evt_id), 32'(exp_id));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        rst_n          = 1'b0;
        bus.req_pulse  = '0;
        bus.err_clr    = 1'b0;
        bus.ack_toggle = 1'b0;

        // 1. single pulse on source 2, ack five cycles after the event
        reset_dut();
        drive(4'b0100, 1'b0);                  // now at t+1
        check("t1_pend_before", 32'(bus.pend_mask), 32'h4);
        check("t1_cnt2", 32'(cnt_of(2)), 32'd1);
        check("t1_busy_idle", 32'(bus.busy), 32'd0);
        exp_q.push_back(2'd2);
        wait_evt(w);                           // evt at t+2
        check("t1_latency", 32'(w), 32'd1);
        check_next_id("t1_id");
        check("t1_busy", 32'(bus.busy), 32'd1);
        check("t1_pend_after", 32'(bus.pend_mask), 32'h0);
        skip(1);
        check("t1_pulse_one_cycle", 32'(bus.evt_pulse), 32'd0);
        skip(4);                               // e+5
        check("t1_busy_hold", 32'(bus.busy), 32'd1);
        check("t1_id_hold", 32'(bus.evt_id), 32'd2);
        ack();
        skip(1);
        check("t1_busy_fall", 32'(bus.busy), 32'd0);

        // 2. all four sources at once, served 0,1,2,3 at 3-cycle spacing
        reset_dut();
        drive(4'b1111, 1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back(ID_W'(i));
        for (int i = 0; i < 4; i++) begin
            wait_evt(w);
            check("t2_spacing", 32'(w), 32'd1);
            check_next_id("t2_id");
            if (i == 0) check("t2_pend_first", 32'(bus.pend_mask), 32'he);
            skip(1);
            ack();
            skip(1);
        end
        check("t2_busy_end", 32'(bus.busy), 32'd0);
        check("t2_pend_end", 32'(bus.pend_mask), 32'h0);
        check("t2_cnts_end", 32'(bus.cnt_dbg), 32'h0);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3. 17 pulses on source 1, no acks; last pulse with err_clr
        reset_dut();
        for (int i = 0; i < 17; i++) begin
            bus.req_pulse = 4'b0010;
            bus.err_clr   = (i == 16);
            skip(1);
            bus.req_pulse = '0;
            bus.err_clr   = 1'b0;
            if (i == 15) begin
                check("t3_cnt_full", 32'(cnt_of(1)), 32'd15);
                check("t3_ovf_not_yet", 32'(bus.ovf_flag), 32'h0);
            end
        end
        check("t3_cnt_sat", 32'(cnt_of(1)), 32'd15);
        check("t3_ovf_set_wins", 32'(bus.ovf_flag), 32'h2);
        check("t3_busy", 32'(bus.busy), 32'd1);
        drive(4'b0000, 1'b1);
        check("t3_ovf_cleared", 32'(bus.ovf_flag), 32'h0);
        check("t3_cnt_kept", 32'(cnt_of(1)), 32'd15);

        // 4. no ack: timeout, then next source served; ack/timeout collision
        reset_dut();
        drive(4'b1001, 1'b0);
        exp_q.push_back(2'd0);
        wait_evt(w);
        check_next_id("t4_id0");
        skip(TIMEOUT);                         // last waiting cycle
        check("t4_tflag_early", 32'(bus.timeout_flag), 32'd0);
        check("t4_busy_wait", 32'(bus.busy), 32'd1);
        skip(1);
        check("t4_tflag_set", 32'(bus.timeout_flag), 32'd1);
        check("t4_busy_idle", 32'(bus.busy), 32'd0);
        check("t4_pend", 32'(bus.pend_mask), 32'h8);
        skip(1);
        exp_q.push_back(2'd3);
        check("t4_next_evt", 32'(bus.evt_pulse), 32'd1);
        check_next_id("t4_id3");
        skip(1);
        ack();
        skip(1);
        check("t4_busy_after_ack", 32'(bus.busy), 32'd0);
        check("t4_tflag_sticky", 32'(bus.timeout_flag), 32'd1);
        drive(4'b0000, 1'b1);
        check("t4_tflag_clear", 32'(bus.timeout_flag), 32'd0);
        drive(4'b0100, 1'b0);
        wait_evt(w);
        skip(TIMEOUT);
        ack();                                 // ack in the timeout cycle
        skip(1);
        check("t4_ack_wins_flag", 32'(bus.timeout_flag), 32'd0);
        check("t4_ack_wins_busy", 32'(bus.busy), 32'd0);

        // 5. new pulse in the same cycle as its own grant
        reset_dut();
        drive(4'b0001, 1'b0);                  // t+1: grant cycle
        drive(4'b0001, 1'b0);                  // t+2
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        check("t5_evt", 32'(bus.evt_pulse), 32'd1);
        check_next_id("t5_id_a");
        check("t5_cnt_kept", 32'(cnt_of(0)), 32'd1);
        skip(1);
        ack();
        skip(1);
        wait_evt(w);
        check("t5_second_spacing", 32'(w), 32'd1);
        check_next_id("t5_id_b");
        skip(1);
        ack();
        skip(1);
        check("t5_pend_end", 32'(bus.pend_mask), 32'h0);

        // 6. reset while waiting with three sources still pending
        reset_dut();
        drive(4'b1111, 1'b0);
        wait_evt(w);
        skip(1);
        check("t6_busy", 32'(bus.busy), 32'd1);
        check("t6_pend", 32'(bus.pend_mask), 32'he);
        rst_n = 1'b0;
        skip(1);
        check_zero("t6_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            skip(1);
            check("t6_quiet", {29'd0, bus.evt_pulse, bus.busy, |bus.pend_mask}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
